// File: rtl/dyn_pattern_detector_param.sv
// Serial bit-stream pattern detector with a runtime-loadable pattern of
// 1..MAX_LEN bits, overlapping / non-overlapping match modes and a saturating
// match counter. Two states: IDLE (no legal pattern) and RUN (detecting).
module dyn_pattern_detector_param #(
  parameter int MAX_LEN = 8,   // maximum pattern length in bits (>= 2)
  parameter int LEN_W   = 4,   // must hold MAX_LEN
  parameter int CNT_W   = 8    // match counter width
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               overlap_i,
  input  logic               clr_cnt_i,
  input  logic               d_i,
  input  logic               v_i,
  output logic               pattern_detect,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               armed_o,
  output logic               cfg_err_o
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [LEN_W:0]   MAX_FILL = (LEN_W + 1)'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W:0]     fill_inc;
  logic               ovl_q;
  logic               det_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               len_ok;
  logic               shift_en;
  logic               match;

  // Next history, length mask, match decision, fill and counter next-state.
  always_comb begin
    // NOTE: every signal driven here gets an unconditional value first, so no
    // path through the block can leave one unassigned and infer a latch.
    len_mask = '0;
    len_ok   = (len_i != '0) && ({1'b0, len_i} <= MAX_FILL);
    // A load in the same cycle takes priority: that data bit is dropped.
    shift_en = (state_q == RUN) && v_i && !load_i;
    hist_d   = {hist_q[MAX_LEN-2:0], d_i};
    fill_inc = {1'b0, fill_q} + 1'b1;

    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    // Only the low len bits take part; older history above them is masked.
    match = shift_en
         && (fill_inc >= {1'b0, len_q})
         && (((hist_d ^ pat_q) & len_mask) == '0);

    if (match && !ovl_q) begin
      fill_d = '0;                       // next match needs len fresh bits
    end else if (fill_inc >= MAX_FILL) begin
      fill_d = LEN_W'(MAX_LEN);
    end else begin
      fill_d = fill_inc[LEN_W-1:0];
    end

    // Clear beats a simultaneous match.
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, configuration, history and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      det_q <= match;
      cnt_q <= cnt_d;
      if (load_i) begin
        hist_q <= '0;
        fill_q <= '0;
        if (len_ok) begin
          pat_q   <= pat_i;
          len_q   <= len_i;
          ovl_q   <= overlap_i;
          err_q   <= 1'b0;
          state_q <= RUN;
        end else begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end
      end else if (shift_en) begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
    end
  end

  assign pattern_detect = det_q;
  assign match_cnt_o    = cnt_q;
  assign armed_o        = (state_q == RUN);
  assign cfg_err_o      = err_q;

endmodule

// File: tb/tb_dyn_pattern_detector_param.sv
// Bench for dyn_pattern_detector_param: two instances (8-bit and 2-bit match
// counters) share one stimulus stream. The driver updates a reference model
// kept as a queue of received bits and pushes the expected post-edge outputs;
// a monitor on the falling edge pops and compares.
module tb_dyn_pattern_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  typedef struct {
    bit       det;
    bit [7:0] cnt8;
    bit [1:0] cnt2;
    bit       armed;
    bit       err;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               load_i;
  logic [MAX_LEN-1:0] pat_i;
  logic [LEN_W-1:0]   len_i;
  logic               overlap_i;
  logic               clr_cnt_i;
  logic               d_i;
  logic               v_i;
  logic               pattern_detect, det2;
  logic [7:0]         match_cnt_o;
  logic [1:0]         cnt2;
  logic               armed_o, armed2;
  logic               cfg_err_o, err2;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model state
  bit       m_armed, m_err, m_ovl;
  bit [7:0] m_pat;
  int       m_len;
  bit       m_bits[$];      // bits received since arming / last non-overlap match
  int       m_cnt8, m_cnt2;

  dyn_pattern_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .pat_i(pat_i), .len_i(len_i),
    .overlap_i(overlap_i), .clr_cnt_i(clr_cnt_i), .d_i(d_i), .v_i(v_i),
    .pattern_detect(pattern_detect), .match_cnt_o(match_cnt_o),
    .armed_o(armed_o), .cfg_err_o(cfg_err_o)
  );

  dyn_pattern_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .load_i(load_i), .pat_i(pat_i), .len_i(len_i),
    .overlap_i(overlap_i), .clr_cnt_i(clr_cnt_i), .d_i(d_i), .v_i(v_i),
    .pattern_detect(det2), .match_cnt_o(cnt2),
    .armed_o(armed2), .cfg_err_o(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Last len received bits equal the pattern; the newest bit is pat[0].
  function automatic bit model_hit();
    if (m_bits.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock of stimulus: drive, update model, push expectation, clock.
  task automatic step(input bit ld, input bit [7:0] pat, input bit [3:0] len,
                      input bit ovl, input bit clr, input bit d, input bit v,
                      input bit r);
    exp_t e;
    bit   hit;
    load_i = ld; pat_i = pat; len_i = len; overlap_i = ovl;
    clr_cnt_i = clr; d_i = d; v_i = v; rst = r;
    hit = 1'b0;
    if (r) begin
      m_armed = 0; m_err = 0; m_ovl = 0; m_pat = 0; m_len = 0;
      m_bits.delete(); m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (ld) begin
        m_bits.delete();
        if (len >= 1 && len <= MAX_LEN) begin
          m_pat = pat; m_len = len; m_ovl = ovl; m_armed = 1; m_err = 0;
        end else begin
          m_err = 1; m_armed = 0;
        end
      end else if (m_armed && v) begin
        m_bits.push_back(d);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        hit = model_hit();
        if (hit && !m_ovl) m_bits.delete();
      end
      if (clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    e.det = hit; e.cnt8 = m_cnt8[7:0]; e.cnt2 = m_cnt2[1:0];
    e.armed = m_armed; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit d, input bit v = 1'b1);
    step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, d, v, 1'b0);
  endtask

  task automatic load(input bit [7:0] pat, input bit [3:0] len, input bit ovl,
                      input bit clr);
    step(1'b1, pat, len, ovl, clr, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input bit [7:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      if (gaps) send(~bits[i], 1'b0);
    end
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("detect",  int'(pattern_detect), int'(mon_e.det));
      check("cnt8",    int'(match_cnt_o),    int'(mon_e.cnt8));
      check("armed",   int'(armed_o),        int'(mon_e.armed));
      check("cfg_err", int'(cfg_err_o),      int'(mon_e.err));
      check("detect2", int'(det2),           int'(mon_e.det));
      check("cnt2",    int'(cnt2),           int'(mon_e.cnt2));
      check("armed2",  int'(armed2),         int'(mon_e.armed));
      check("cfg_err2",int'(err2),           int'(mon_e.err));
    end
  end

  initial begin
    int exp5[5];
    exp5[0] = 1; exp5[1] = 2; exp5[2] = 3; exp5[3] = 3; exp5[4] = 3;

    // Reset
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_cnt", int'(match_cnt_o), 0);
    check("rst_armed", int'(armed_o), 0);

    // 1: overlapping 1011 in 1011011 -> two detects
    load(8'h0B, 4'd4, 1'b1, 1'b0);
    send_bits(8'b0101_1011, 7, 1'b0);
    check("t1_cnt", int'(match_cnt_o), 2);

    // 2: non-overlapping -> one detect
    load(8'h0B, 4'd4, 1'b0, 1'b1);
    send_bits(8'b0101_1011, 7, 1'b0);
    check("t2_cnt", int'(match_cnt_o), 1);

    // 3: overlapping with idle gaps carrying inverted data
    load(8'h0B, 4'd4, 1'b1, 1'b1);
    send_bits(8'b0101_1011, 7, 1'b1);
    check("t3_cnt", int'(match_cnt_o), 2);

    // 4: illegal lengths 0 and 9, then legal reload
    load(8'h01, 4'd0, 1'b1, 1'b1);
    check("t4_err0", int'(cfg_err_o), 1);
    check("t4_arm0", int'(armed_o), 0);
    repeat (4) send(1'b1);
    load(8'h01, 4'd9, 1'b1, 1'b0);
    check("t4_err9", int'(cfg_err_o), 1);
    repeat (4) send(1'b1);
    check("t4_nocnt", int'(match_cnt_o), 0);
    load(8'h01, 4'd1, 1'b1, 1'b0);
    check("t4_errclr", int'(cfg_err_o), 0);
    check("t4_armed", int'(armed_o), 1);

    // 5: len=1 pattern 1, 2-bit counter saturates, then clears
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send(1'b1);
      check("t5_cnt2", int'(cnt2), exp5[i]);
    end
    step(0, 0, 0, 0, 1, 1, 1, 0);   // clear with simultaneous match
    check("t5_clr", int'(cnt2), 0);
    check("t5_clr8", int'(match_cnt_o), 0);

    // 6: reset mid-pattern, reload, lone 4th bit must not match
    load(8'h0B, 4'd4, 1'b1, 1'b0);
    send_bits(8'b0000_0101, 3, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("t6_rst_arm", int'(armed_o), 0);
    load(8'h0B, 4'd4, 1'b1, 1'b0);
    send(1'b1);
    check("t6_nodet", int'(pattern_detect), 0);
    send_bits(8'b0000_1011, 4, 1'b0);
    check("t6_det", int'(pattern_detect), 1);

    // Random stream against the model
    load(8'($urandom), 4'($urandom_range(1, 4)), 1'($urandom), 1'b1);
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 49) == 0)
        load(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom), 1'b0);
      else
        step(0, 0, 0, 0, ($urandom_range(0, 39) == 0), 1'($urandom),
             ($urandom_range(0, 3) != 0), 0);
    end

    repeat (3) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
